// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer block.
// The optional second bank is enabled by defining FRAMEBUFFER_DOUBLE_BUFFER_EN.
package fb_pkg;

    // Default visible resolution.
    localparam int FB_WIDTH  = 400;
    localparam int FB_HEIGHT = 240;

    // One spare bit on each coordinate so out-of-range values can be represented and rejected.
    localparam int FB_X_W = $clog2(FB_WIDTH) + 1;
    localparam int FB_Y_W = $clog2(FB_HEIGHT) + 1;

    // Bit 0 of a pixel is its opacity flag. The GPU has already filtered on it, so the store ignores it.
    localparam int OPAQUE_BIT = 0;

    typedef logic [15:0] pixel_t;

    // Bank-swap controller states.
    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

    // Convenience accessor for the opacity flag.
    function automatic logic is_opaque(input pixel_t px);
        return px[OPAQUE_BIT];
    endfunction

endpackage

// File: rtl/fb_bank.sv
// One pixel bank: simple dual-port RAM with one write port and one registered read port.
// A read and a write to the same address in the same cycle return the old data (read-first).
module fb_bank
    import fb_pkg::*;
#(
    parameter int DEPTH = 96000,
    parameter int AW    = 17
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pixel_t        wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output pixel_t        rdata
);

    pixel_t mem [DEPTH];

    // Write port: one pixel per cycle. Contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port. A nonblocking read next to a nonblocking write gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/framebuffer.sv
// Pixel store between the GPU write interface and the display scan-out port.
// The GPU writes the back bank and the display reads the front bank. A bank swap
// takes effect only at a frame start, so a displayed frame never tears.
// When FRAMEBUFFER_DOUBLE_BUFFER_EN is undefined, a single bank is shared by reads
// and writes, and the swap inputs are ignored.
module framebuffer #(
    parameter int FB_WIDTH   = fb_pkg::FB_WIDTH,
    parameter int FB_HEIGHT  = fb_pkg::FB_HEIGHT,
    parameter int RD_LATENCY = 2   // fixed; only 2 is supported
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(FB_WIDTH):0]   wr_x,
    input  logic [$clog2(FB_HEIGHT):0]  wr_y,
    input  fb_pkg::pixel_t              wr_color,
    input  logic                        wr_en,
    input  logic [$clog2(FB_WIDTH):0]   rd_x,
    input  logic [$clog2(FB_HEIGHT):0]  rd_y,
    input  logic                        rd_en,
    output fb_pkg::pixel_t              rd_color,
    output logic                        rd_valid,
    input  logic                        frame_start,
    input  logic                        swap_req,
    output logic                        swap_pending,
    output logic                        front_sel
);
    import fb_pkg::*;

    localparam int X_W   = $clog2(FB_WIDTH) + 1;
    localparam int Y_W   = $clog2(FB_HEIGHT) + 1;
    localparam int DEPTH = FB_WIDTH * FB_HEIGHT;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [X_W-1:0] X_LIM = X_W'(FB_WIDTH);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(FB_HEIGHT);

`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    // Address math and bounds checks. Out-of-range coordinates may alias, but they are gated off.
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          wr_ok;
    logic          rd_ok;

    assign wr_addr = AW'(wr_y) * AW'(FB_WIDTH) + AW'(wr_x);
    assign rd_addr = AW'(rd_y) * AW'(FB_WIDTH) + AW'(rd_x);
    assign wr_ok   = wr_en && (wr_x < X_LIM) && (wr_y < Y_LIM);
    assign rd_ok   = rd_en && (rd_x < X_LIM) && (rd_y < Y_LIM);

    // Pixel banks. A write targets the bank that is not currently displayed.
    pixel_t bank_q [NUM_BANKS];

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        localparam logic BANK_ID = 1'(gi);
        logic bank_we;

        assign bank_we = wr_ok && ((NUM_BANKS == 1) || (front_sel != BANK_ID));

        fb_bank #(
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we),
            .waddr (wr_addr),
            .wdata (wr_color),
            .re    (rd_ok),
            .raddr (rd_addr),
            .rdata (bank_q[gi])
        );
    end

    // Stage 1 lives partly in the RAM: its read register holds the addressed pixel, while
    // these registers carry valid, in-bounds and bank alongside it.
    pixel_t rd_sel;

`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
    swap_state_t state_reg;
    logic        front_sel_reg;
    logic        old_swap_req;
    logic        s1_bank_reg;
    logic        swap_edge;

    assign swap_edge = swap_req && !old_swap_req;

    // Swap controller. A request waits for frame_start. If it coincides with frame_start, it swaps at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SWAP_IDLE;
            front_sel_reg <= 1'b0;
            old_swap_req  <= 1'b0;
        end else begin
            old_swap_req <= swap_req;
            case (state_reg)
                SWAP_IDLE: begin
                    if (swap_edge) begin
                        if (frame_start) begin
                            front_sel_reg <= ~front_sel_reg;
                        end else begin
                            state_reg <= SWAP_PENDING;
                        end
                    end
                end
                SWAP_PENDING: begin
                    // Extra request edges while pending fold into the one outstanding swap.
                    if (frame_start) begin
                        front_sel_reg <= ~front_sel_reg;
                        state_reg     <= SWAP_IDLE;
                    end
                end
                default: state_reg <= SWAP_IDLE;
            endcase
        end
    end

    // Capture the bank at request time, so a swap does not redirect reads already in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_bank_reg <= 1'b0;
        end else begin
            s1_bank_reg <= front_sel_reg;
        end
    end

    assign front_sel    = front_sel_reg;
    assign swap_pending = (state_reg == SWAP_PENDING);
    assign rd_sel       = s1_bank_reg ? bank_q[1] : bank_q[0];
`else
    logic unused_swap_inputs;
    assign unused_swap_inputs = &{1'b0, swap_req, frame_start};

    assign front_sel    = 1'b0;
    assign swap_pending = 1'b0;
    assign rd_sel       = bank_q[0];
`endif

    logic [RD_LATENCY-1:0] rd_vld_reg;
    logic                  s1_in_reg;
    pixel_t                rd_color_reg;

    // Read pipeline. Stage 2 registers the selected bank output; an out-of-bounds read yields zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_reg   <= '0;
            s1_in_reg    <= 1'b0;
            rd_color_reg <= '0;
        end else begin
            rd_vld_reg   <= {rd_vld_reg[RD_LATENCY-2:0], rd_en};
            s1_in_reg    <= rd_ok;
            rd_color_reg <= s1_in_reg ? rd_sel : '0;
        end
    end

    assign rd_valid = rd_vld_reg[RD_LATENCY-1];
    assign rd_color = rd_color_reg;

endmodule

// File: tb/tb_framebuffer.sv
// Directed self-checking bench for framebuffer. It builds against both configurations:
// expectations depend on whether FRAMEBUFFER_DOUBLE_BUFFER_EN is defined.
module tb_framebuffer;
    import fb_pkg::*;

`ifdef FRAMEBUFFER_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [FB_X_W-1:0] wr_x;
    logic [FB_Y_W-1:0] wr_y;
    pixel_t            wr_color;
    logic              wr_en;
    logic [FB_X_W-1:0] rd_x;
    logic [FB_Y_W-1:0] rd_y;
    logic              rd_en;
    pixel_t            rd_color;
    logic              rd_valid;
    logic              frame_start;
    logic              swap_req;
    logic              swap_pending;
    logic              front_sel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    framebuffer #(
        .FB_WIDTH   (FB_WIDTH),
        .FB_HEIGHT  (FB_HEIGHT),
        .RD_LATENCY (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_x         (wr_x),
        .wr_y         (wr_y),
        .wr_color     (wr_color),
        .wr_en        (wr_en),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_en        (rd_en),
        .rd_color     (rd_color),
        .rd_valid     (rd_valid),
        .frame_start  (frame_start),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .front_sel    (front_sel)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic pixel_t pat(input int x);
        return 16'h5000 | 16'(x);
    endfunction

    task automatic write_px(input int x, input int y, input pixel_t c);
        wr_x     = FB_X_W'(x);
        wr_y     = FB_Y_W'(y);
        wr_color = c;
        wr_en    = 1'b1;
        tick();
        wr_en = 1'b0;
        $display("write (%0d,%0d) <= %h", x, y, c);
    endtask

    // Request at cycle N: not valid at N+1, valid with data at N+2.
    task automatic read_px(input string tag, input int x, input int y, input pixel_t exp);
        rd_x  = FB_X_W'(x);
        rd_y  = FB_Y_W'(y);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_val({tag, "_early"}, rd_valid, 0);
        tick();
        check_val({tag, "_valid"}, rd_valid, 1);
        check_val({tag, "_data"}, rd_color, exp);
        $display("read  (%0d,%0d) -> %h valid=%0b", x, y, rd_color, rd_valid);
    endtask

    // Swap request edge that coincides with frame_start: immediate swap.
    task automatic swap_now();
        swap_req = 1'b0;
        tick();
        swap_req    = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        swap_req    = 1'b0;
        $display("swap  front_sel=%0b", front_sel);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int bad_vld;
        int bad_data;
        int n_vld;

        reset = 1'b1; wr_x = '0; wr_y = '0; wr_color = '0; wr_en = 1'b0;
        rd_x = '0; rd_y = '0; rd_en = 1'b0; frame_start = 1'b0; swap_req = 1'b0;
        repeat (3) tick();
        check_val("rst_rd_valid", rd_valid, 0);
        check_val("rst_rd_color", rd_color, 0);
        check_val("rst_front_sel", front_sel, 0);
        check_val("rst_swap_pending", swap_pending, 0);
        reset = 1'b0;
        tick();

        // Write/read latency across a deferred swap.
        write_px(5, 7, 16'hABCD);
        swap_req = 1'b1;
        tick();
        check_val("t1_pending", swap_pending, DB);
        check_val("t1_front_hold", front_sel, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_val("t1_front", front_sel, DB);
        check_val("t1_pending_clr", swap_pending, 0);
        read_px("t1_rd", 5, 7, 16'hABCD);

        // Deferred swap held for 1000 cycles; a second request edge must not add a swap.
        swap_req = 1'b0;
        tick();
        swap_req = 1'b1;
        tick();
        check_val("t2_pending", swap_pending, DB);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) swap_req = 1'b0;
            if (i == 501) swap_req = 1'b1;
            tick();
            if (front_sel !== DB || swap_pending !== DB) bad++;
        end
        check_val("t2_hold", bad, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_val("t2_front", front_sel, 0);
        check_val("t2_pending_clr", swap_pending, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_val("t2_single_swap", front_sel, 0);
        $display("deferred swap done, front_sel=%0b", front_sel);

        // Request edge coincides with frame_start.
        swap_req = 1'b0;
        tick();
        swap_req    = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_val("t3_front", front_sel, DB);
        check_val("t3_pending", swap_pending, 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (swap_pending !== 1'b0) bad++;
        end
        check_val("t3_never_pending", bad, 0);
        swap_req = 1'b0;

        // Bounds: out-of-range writes are dropped, and an out-of-range read returns zero.
        write_px(399, 0, 16'h1111);
        write_px(0, 239, 16'h2222);
        write_px(0, 1, 16'h3333);
        write_px(400, 0, 16'hFFFF);
        write_px(0, 240, 16'hFFFF);
        swap_now();
        read_px("t4_edge_x", 399, 0, 16'h1111);
        read_px("t4_edge_y", 0, 239, 16'h2222);
        read_px("t4_alias", 0, 1, 16'h3333);
        read_px("t4_oob_x", 400, 10, 16'h0000);
        read_px("t4_oob_y", 0, 240, 16'h0000);

        // Prefill row 0 of the back bank with a pattern, then make it the front bank.
        for (int x = 0; x < FB_WIDTH; x++) begin
            wr_x = FB_X_W'(x); wr_y = '0; wr_color = pat(x); wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        $display("write row 0 <= pattern");
        swap_now();

        // Stream 400 reads of row 0 while the GPU writes the same row.
        bad_vld = 0; bad_data = 0; n_vld = 0;
        for (int i = 0; i <= FB_WIDTH; i++) begin
            if (i < FB_WIDTH) begin
                rd_en = 1'b1; rd_x = FB_X_W'(i); rd_y = '0;
                wr_en = 1'b1; wr_x = FB_X_W'(i); wr_y = '0; wr_color = 16'h1235;
            end else begin
                rd_en = 1'b0;
                wr_en = 1'b0;
            end
            tick();
            if (i >= 1) begin
                if (rd_valid !== 1'b1) bad_vld++;
                else n_vld++;
                if (rd_color !== pat(i - 1)) bad_data++;
            end
        end
        tick();
        check_val("t5_gaps", bad_vld, 0);
        check_val("t5_count", n_vld, FB_WIDTH);
        check_val("t5_old_data", bad_data, 0);
        check_val("t5_tail", rd_valid, 0);
        $display("stream row 0: %0d results", n_vld);

        // The streamed writes landed in the other bank.
        swap_now();
        read_px("t5_new_10", 10, 0, 16'h1235);
        read_px("t5_new_399", 399, 0, 16'h1235);
        swap_now();
        check_val("t6_front_pre", front_sel, DB);

        // Reset with a swap pending and two reads in flight.
        swap_req = 1'b0;
        tick();
        swap_req = 1'b1;
        tick();
        check_val("t6_pending_pre", swap_pending, DB);
        rd_x = FB_X_W'(3); rd_y = '0; rd_en = 1'b1;
        tick();
        tick();
        rd_en = 1'b0; reset = 1'b1; swap_req = 1'b0;
        tick();
        check_val("t6_front", front_sel, 0);
        check_val("t6_pending", swap_pending, 0);
        check_val("t6_rd_valid", rd_valid, 0);
        check_val("t6_rd_color", rd_color, 0);
        reset = 1'b0;
        tick();
        check_val("t6_flushed", rd_valid, 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        check_val("t6_no_swap", front_sel, 0);
        check_val("t6_no_pending", swap_pending, 0);
        $display("reset mid-operation done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
